// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor slice, LSB first, one bit per cycle.
// Operands are captured on the accepting edge; result is held until the next start.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             d_bit;
    logic             br_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        d_bit   = a_q[0] ^ b_q[0] ^ br_q;
        br_nx   = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d    = {1'b0, a_q[WIDTH-1:1]};
                b_d    = {1'b0, b_q[WIDTH-1:1]};
                br_d   = br_nx;
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                // Final borrow of the last slice is the borrow-out.
                bout_d = br_nx;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign diff  = diff_q;
    assign bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vectors plus a random sweep at
// WIDTH=8 and WIDTH=16, checked against a timeline/arithmetic model.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st[2];
    logic [31:0] ai[2];
    logic [31:0] bi[2];
    logic        ci[2];

    logic        rdy0, bsy0, dn0, bo0;
    logic [7:0]  df0;
    logic        rdy1, bsy1, dn1, bo1;
    logic [15:0] df1;

    int checks   = 0;
    int failures = 0;
    int W[2]     = '{8, 16};

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st[0]),
        .a(ai[0][7:0]), .b(bi[0][7:0]), .bin(ci[0]),
        .ready(rdy0), .busy(bsy0), .done(dn0),
        .diff(df0), .bout(bo0)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(st[1]),
        .a(ai[1][15:0]), .b(bi[1][15:0]), .bin(ci[1]),
        .ready(rdy1), .busy(bsy1), .done(dn1),
        .diff(df1), .bout(bo1)
    );

    function automatic logic [31:0] msk(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] ref_diff(input int w,
        input logic [31:0] x, input logic [31:0] y, input logic c);
        longint r;
        r = longint'(x & msk(w)) - longint'(y & msk(w)) - longint'(c);
        return 32'(r) & msk(w);
    endfunction

    function automatic logic ref_bout(input int w,
        input logic [31:0] x, input logic [31:0] y, input logic c);
        return longint'(x & msk(w)) < (longint'(y & msk(w)) + longint'(c));
    endfunction

    function automatic logic get_rdy(input int i);
        return (i == 0) ? rdy0 : rdy1;
    endfunction
    function automatic logic get_bsy(input int i);
        return (i == 0) ? bsy0 : bsy1;
    endfunction
    function automatic logic get_dn(input int i);
        return (i == 0) ? dn0 : dn1;
    endfunction
    function automatic logic get_bo(input int i);
        return (i == 0) ? bo0 : bo1;
    endfunction
    function automatic logic [31:0] get_df(input int i);
        return (i == 0) ? {24'd0, df0} : {16'd0, df1};
    endfunction

    task automatic chk(input string nm, input int i,
        input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[w%0d] got=%0h want=%0h t=%0t",
                     nm, W[i], got, exp, $time);
        end
    endtask

    // Model: k = cycles since acceptance (-1 idle, -2 before first reset).
    int          k[2]  = '{-2, -2};
    logic [31:0] pd[2];
    logic        pb[2];
    logic [31:0] ed[2];
    logic        eb[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                k[i]  = -1;
                ed[i] = '0;
                eb[i] = 1'b0;
            end else if (k[i] == -2) begin
                k[i] = -2;
            end else if (k[i] < 0) begin
                if (st[i]) begin
                    k[i]  = 0;
                    pd[i] = ref_diff(W[i], ai[i], bi[i], ci[i]);
                    pb[i] = ref_bout(W[i], ai[i], bi[i], ci[i]);
                end
            end else if (k[i] == W[i]) begin
                k[i] = -1;
            end else begin
                k[i] = k[i] + 1;
                if (k[i] == W[i]) begin
                    ed[i] = pd[i];
                    eb[i] = pb[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (k[i] != -2) begin
                chk("ready", i, 32'(get_rdy(i)), 32'(k[i] < 0));
                chk("busy", i, 32'(get_bsy(i)), 32'(k[i] >= 0 && k[i] < W[i]));
                chk("done", i, 32'(get_dn(i)), 32'(k[i] == W[i]));
                if (k[i] < 0 || k[i] == W[i]) begin
                    chk("diff", i, get_df(i), ed[i]);
                    chk("bout", i, 32'(get_bo(i)), 32'(eb[i]));
                end
            end
        end
    end

    task automatic run_op(input int i, input logic [31:0] av,
        input logic [31:0] bv, input logic c,
        output logic [31:0] d, output logic bo,
        output int lat, output int bc, output logic ok);
        @(posedge clk);
        #2;
        ai[i] = av;
        bi[i] = bv;
        ci[i] = c;
        st[i] = 1'b1;
        @(posedge clk);
        #2;
        st[i] = 1'b0;
        ai[i] = $urandom & msk(W[i]);
        bi[i] = $urandom & msk(W[i]);
        ci[i] = 1'($urandom);
        lat = 0;
        bc  = 0;
        d   = '0;
        bo  = 1'b0;
        ok  = 1'b0;
        for (int n = 0; n < 4 * W[i] + 10; n++) begin
            @(negedge clk);
            if (get_dn(i)) begin
                d  = get_df(i);
                bo = get_bo(i);
                ok = 1'b1;
                break;
            end
            if (get_bsy(i)) bc++;
            @(posedge clk);
            lat++;
        end
        if (!ok) chk("timeout", i, 32'd0, 32'd1);
    endtask

    task automatic dir8(input string nm, input logic [31:0] av,
        input logic [31:0] bv, input logic c,
        input logic [31:0] xd, input logic xb);
        logic [31:0] d;
        logic        bo, ok;
        int          lat, bc;
        run_op(0, av, bv, c, d, bo, lat, bc, ok);
        chk({nm, "_diff"}, 0, d, xd);
        chk({nm, "_bout"}, 0, 32'(bo), 32'(xb));
        chk({nm, "_lat"}, 0, 32'(lat), 32'd8);
        chk({nm, "_busy"}, 0, 32'(bc), 32'd8);
    endtask

    initial begin
        int nd, t0, t1;
        logic seen, ok;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0;
            ai[i] = '0;
            bi[i] = '0;
            ci[i] = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 0, 32'(rdy0), 32'd1);
        chk("rst_busy", 0, 32'(bsy0), 32'd0);
        chk("rst_done", 0, 32'(dn0), 32'd0);
        chk("rst_diff", 0, {24'd0, df0}, 32'd0);
        chk("rst_bout", 0, 32'(bo0), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        dir8("basic", 32'h50, 32'h20, 1'b0, 32'h30, 1'b0);
        dir8("under", 32'h00, 32'h01, 1'b0, 32'hFF, 1'b1);
        dir8("binff", 32'hFF, 32'hFF, 1'b1, 32'hFF, 1'b1);
        dir8("bin10", 32'h10, 32'h0F, 1'b1, 32'h00, 1'b0);
        dir8("eq0", 32'h5A, 32'h5A, 1'b0, 32'h00, 1'b0);
        dir8("eq1", 32'h5A, 32'h5A, 1'b1, 32'hFF, 1'b1);
        dir8("wrap", 32'h03, 32'h80, 1'b1, 32'h82, 1'b1);

        // start held high while operands churn every cycle
        @(posedge clk);
        #2;
        st[0] = 1'b1;
        ai[0] = 32'h11;
        bi[0] = 32'h22;
        @(posedge clk);
        nd = 0;
        t0 = -1;
        t1 = -1;
        for (int j = 0; j < 30; j++) begin
            #2;
            ai[0] = $urandom & 32'hFF;
            bi[0] = $urandom & 32'hFF;
            ci[0] = 1'($urandom);
            @(negedge clk);
            if (dn0) begin
                nd++;
                if (t0 < 0) t0 = j;
                else if (t1 < 0) t1 = j;
            end
            @(posedge clk);
        end
        #2;
        st[0] = 1'b0;
        chk("held_dones", 0, 32'(nd), 32'd3);
        chk("held_first", 0, 32'(t0), 32'd8);
        chk("held_period", 0, 32'(t1 - t0), 32'd10);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rdy0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("held_idle", 0, 32'(ok), 32'd1);

        // reset sampled at E0+4 aborts the operation
        @(posedge clk);
        #2;
        ai[0] = 32'h50;
        bi[0] = 32'h20;
        ci[0] = 1'b0;
        st[0] = 1'b1;
        @(posedge clk);
        #2;
        st[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (n == 0) begin
                chk("abort_ready", 0, 32'(rdy0), 32'd1);
                chk("abort_diff", 0, {24'd0, df0}, 32'd0);
                chk("abort_bout", 0, 32'(bo0), 32'd0);
            end
            if (dn0) seen = 1'b1;
        end
        chk("abort_nodone", 0, 32'(seen), 32'd0);
        dir8("after", 32'h07, 32'h03, 1'b0, 32'h04, 1'b0);

        fork
            for (int i = 0; i < 2; i++) begin
                automatic int ii = i;
                fork
                    begin
                        logic [31:0] x, y, d;
                        logic c, bo, okk;
                        int lat, bc;
                        for (int n = 0; n < 1000; n++) begin
                            x = $urandom & msk(W[ii]);
                            y = $urandom & msk(W[ii]);
                            c = 1'($urandom);
                            run_op(ii, x, y, c, d, bo, lat, bc, okk);
                            chk("rnd_diff", ii, d, ref_diff(W[ii], x, y, c));
                            chk("rnd_bout", ii, 32'(bo),
                                32'(ref_bout(W[ii], x, y, c)));
                        end
                    end
                join_none
            end
        join
        wait fork;

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, a synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a subtraction.
REQ-005 The block SHALL have port a, input, WIDTH bits, the minuend.
REQ-006 The block SHALL have port b, input, WIDTH bits, the subtrahend.
REQ-007 The block SHALL have port bin, input, 1 bit, the borrow-in.
REQ-008 The block SHALL have port ready, output, 1 bit, which is high when a start will be accepted.
REQ-009 The block SHALL have port busy, output, 1 bit, which is high while bits are being processed.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse signalling that the result is valid.
REQ-011 The block SHALL have port diff, output, WIDTH bits, the difference.
REQ-012 The block SHALL have port bout, output, 1 bit, the borrow-out.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 ready SHALL be 1 only in IDLE.
REQ-015 busy SHALL be 1 only in RUN.
REQ-016 done SHALL be 1 only in DONE.
REQ-017 In IDLE with start=1 at a clock edge, the block SHALL capture a, b and bin into internal registers, clear the bit counter, and go to RUN.
REQ-018 start SHALL be ignored in RUN and DONE.
REQ-019 a, b and bin SHALL be sampled only at the accepting edge; later changes on them SHALL have no effect on the result.
REQ-020 The block SHALL process one bit per cycle in RUN, LSB first, using a single-bit full-subtractor slice:
- d = x ^ y ^ br
- br_next = (~x & y) | (~x & br) | (y & br)
- x and y are the current operand bits; br is the borrow register, initialised from bin.
REQ-021 Each d SHALL be shifted into the diff register from the MSB side, so that after WIDTH shifts diff[0] is the LSB result.
REQ-022 RUN SHALL last exactly WIDTH cycles; after the WIDTH-th bit edge the FSM SHALL enter DONE.
REQ-023 The FSM SHALL stay in DONE for one cycle, then return to IDLE.
REQ-024 Latency: if start is accepted at edge E0, done SHALL be high in the cycle after edge E0+WIDTH.
- ready returns high one cycle later.
- Back-to-back throughput is one operation per WIDTH+2 cycles.
REQ-025 In DONE, diff SHALL equal (a - b - bin) mod 2^WIDTH.
REQ-026 In DONE, bout SHALL equal 1 iff a < b + bin (unsigned compare).
REQ-027 diff and bout SHALL hold their values from DONE until the next start is accepted.
REQ-028 During RUN, diff and bout contents SHALL be don't-care and SHALL NOT be relied on.
REQ-029 Boundary: a=b with bin=0 SHALL give diff=0, bout=0.
REQ-030 Boundary: a=b with bin=1 SHALL give diff=all ones, bout=1.
REQ-031 Boundary: wrap-around results SHALL be reported modulo 2^WIDTH, with bout=1.
REQ-032 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-033 While rst_n=0 at a rising edge, the block SHALL force state=IDLE, counter=0, borrow register=0, diff=0, bout=0.
REQ-034 While rst_n=0, the outputs SHALL be ready=1 (after that edge), busy=0, done=0.
REQ-035 Reset SHALL take priority over start.
REQ-036 Reset asserted in RUN or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-037 The first start after rst_n returns high SHALL be accepted normally.

Verification
REQ-038 The bench SHALL cover basic subtraction: WIDTH=8, a=0x50, b=0x20, bin=0, start pulse at E0 -> done=1 in the cycle after E0+8, diff=0x30, bout=0, busy high for 8 cycles.
REQ-039 The bench SHALL cover underflow: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
REQ-040 The bench SHALL cover borrow-in: a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1; and a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
REQ-041 The bench SHALL cover ignored start and input stability: start held high continuously and a/b toggled during RUN -> exactly one done per WIDTH+2 cycles, each result matching the operands captured at acceptance.
REQ-042 The bench SHALL cover reset mid-operation: rst_n=0 for one edge at E0+4 -> no done pulse, diff=0x00, bout=0, ready=1; a subsequent start with 0x07-0x03 -> diff=0x04, bout=0.
REQ-043 The bench SHALL cover a randomized sweep: 1000 random a, b, bin at WIDTH=8 and WIDTH=16 compared against a reference model -> zero mismatches.
